// File: rtl/rv_pkg.sv
// ============================================================================
// Module : rv_pkg
// Shared RV32 opcode constants and the ID->EX payload width helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // instr + pc + rs1data + rs2data + imm + rd_we
  function automatic int payload_w(input int xlen);
    return 32 + 4 * xlen + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_imm_gen.sv
// ============================================================================
// Module : id_imm_gen
// Combinational immediate extraction and rd write-enable decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic            rd_we
);

  logic [6:0]         opcode;
  logic signed [31:0] imm32;

  assign opcode = instr[6:0];

  always_comb begin
    imm32 = '0;
    unique case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {instr[31:12], 12'b0};
      OP_JAL:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      default:   imm32 = '0;
    endcase
  end

  // Signed cast sign-extends to XLEN for RV64 builds
  assign imm   = XLEN'(imm32);
  assign rd_we = (opcode != OP_STORE) && (opcode != OP_BRANCH) &&
                 (instr[7 +: RA_W] != '0);

endmodule

`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
// ============================================================================
// Module : id_ex_pipe_reg
// ID->EX pipeline register with valid/ready handshake, skid entry and flush.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_ex_pipe_reg
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1data,
  input  logic [XLEN-1:0] in_rs2data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [RA_W-1:0] out_rs1addr,
  output logic [RA_W-1:0] out_rs2addr,
  output logic [RA_W-1:0] out_rdaddr,
  output logic [XLEN-1:0] out_rs1data,
  output logic [XLEN-1:0] out_rs2data,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rd_we
);

  localparam int PW = payload_w(XLEN);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1data;
    logic [XLEN-1:0] rs2data;
    logic [XLEN-1:0] imm;
    logic            rd_we;
  } payload_t;

  // State bits are {M.valid, S.valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_t;

  state_t   state_q, state_d;
  payload_t m_q, m_d;
  payload_t s_q, s_d;
  logic     in_ready_q, in_ready_d;

  logic [XLEN-1:0] in_imm;
  logic            in_rd_we;
  logic [PW-1:0]   in_bits;
  logic            accept;
  logic            xfer;

  id_imm_gen #(
    .XLEN (XLEN),
    .RA_W (RA_W)
  ) u_imm_gen (
    .instr (in_instr),
    .imm   (in_imm),
    .rd_we (in_rd_we)
  );

  assign in_bits = {in_instr, in_pc, in_rs1data, in_rs2data, in_imm, in_rd_we};
  assign accept  = in_valid & in_ready_q;
  assign xfer    = state_q[1] & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = EMPTY;
      m_d     = '0;
      s_d     = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = FULL;
            m_d     = payload_t'(in_bits);
          end
        end
        FULL: begin
          if (accept && xfer) begin
            m_d = payload_t'(in_bits);
          end else if (accept) begin
            state_d = SKID;
            s_d     = payload_t'(in_bits);
          end else if (xfer) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (xfer) begin
            state_d = FULL;
            m_d     = s_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != SKID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = state_q[1];
  assign out_instr   = m_q.instr;
  assign out_pc      = m_q.pc;
  assign out_rs1addr = m_q.instr[15 +: RA_W];
  assign out_rs2addr = m_q.instr[20 +: RA_W];
  assign out_rdaddr  = m_q.instr[7 +: RA_W];
  assign out_rs1data = m_q.rs1data;
  assign out_rs2data = m_q.rs2data;
  assign out_imm     = m_q.imm;
  assign out_rd_we   = m_q.rd_we;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
// ============================================================================
// Module : tb_id_ex_pipe_reg
// Directed self-checking bench for id_ex_pipe_reg.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1data;
  logic [31:0] in_rs2data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1addr;
  logic [4:0]  out_rs2addr;
  logic [4:0]  out_rdaddr;
  logic [31:0] out_rs1data;
  logic [31:0] out_rs2data;
  logic [31:0] out_imm;
  logic        out_rd_we;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(32), .RA_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1data  (in_rs1data),
    .in_rs2data  (in_rs2data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_rs1addr (out_rs1addr),
    .out_rs2addr (out_rs2addr),
    .out_rdaddr  (out_rdaddr),
    .out_rs1data (out_rs1data),
    .out_rs2data (out_rs2data),
    .out_imm     (out_imm),
    .out_rd_we   (out_rd_we)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    in_valid   = v;
    in_pc      = pc;
    in_instr   = instr;
    in_rs1data = pc ^ 32'hA5A5_0000;
    in_rs2data = pc ^ 32'h0000_5A5A;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    send(1'b0, 32'h0, 32'h0);
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    step(); step();
    rst = 1'b0;

    // Streaming with decode checks on each entry
    out_ready = 1'b1;
    send(1'b1, 32'h0, 32'h0050_0093);          // addi x1,x0,5
    step();
    check("s0_valid", 64'(out_valid), 64'd1);
    check("s0_pc", 64'(out_pc), 64'h0);
    check("addi_rd", 64'(out_rdaddr), 64'd1);
    check("addi_imm", 64'(out_imm), 64'd5);
    check("addi_we", 64'(out_rd_we), 64'd1);
    check("s0_rs1data", 64'(out_rs1data), 64'hA5A5_0000);
    send(1'b1, 32'h4, 32'hFE11_2E23);          // sw x1,-4(x2)
    step();
    check("s1_pc", 64'(out_pc), 64'h4);
    check("s1_ready", 64'(in_ready), 64'd1);
    check("sw_rs1", 64'(out_rs1addr), 64'd2);
    check("sw_rs2", 64'(out_rs2addr), 64'd1);
    check("sw_imm", 64'(out_imm), 64'hFFFF_FFFC);
    check("sw_we", 64'(out_rd_we), 64'd0);
    send(1'b1, 32'h8, 32'h0000_0013);          // nop
    step();
    check("s2_pc", 64'(out_pc), 64'h8);
    check("nop_we", 64'(out_rd_we), 64'd0);
    check("nop_imm", 64'(out_imm), 64'd0);
    send(1'b1, 32'hC, 32'h1234_52B7);          // lui x5,0x12345
    step();
    check("s3_pc", 64'(out_pc), 64'hC);
    check("s3_ready", 64'(in_ready), 64'd1);
    check("lui_imm", 64'(out_imm), 64'h1234_5000);
    check("lui_we", 64'(out_rd_we), 64'd1);
    send(1'b1, 32'h40, 32'hFE00_0CE3);         // beq x0,x0,-8
    step();
    check("beq_imm", 64'(out_imm), 64'hFFFF_FFF8);
    check("beq_we", 64'(out_rd_we), 64'd0);
    send(1'b1, 32'h44, 32'h0080_00EF);         // jal x1,8
    step();
    check("jal_imm", 64'(out_imm), 64'd8);
    check("jal_we", 64'(out_rd_we), 64'd1);
    send(1'b0, 32'h0, 32'h0);
    step();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_hold_pc", 64'(out_pc), 64'h44);

    // Stall into skid, then drain in order
    out_ready = 1'b0;
    send(1'b1, 32'h10, 32'h0050_0093);
    step();
    check("st0_pc", 64'(out_pc), 64'h10);
    check("st0_ready", 64'(in_ready), 64'd1);
    send(1'b1, 32'h14, 32'h0050_0093);
    step();
    check("skid_ready", 64'(in_ready), 64'd0);
    check("skid_hold_pc", 64'(out_pc), 64'h10);
    send(1'b1, 32'h99, 32'h0050_0093);         // refused while in SKID
    step();
    check("skid_hold2_pc", 64'(out_pc), 64'h10);
    send(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    step();
    check("dr0_pc", 64'(out_pc), 64'h14);
    check("dr0_valid", 64'(out_valid), 64'd1);
    check("dr0_ready", 64'(in_ready), 64'd1);
    step();
    check("dr1_valid", 64'(out_valid), 64'd0);
    check("dr1_pc", 64'(out_pc), 64'h14);

    // Flush while in SKID with a new input presented
    out_ready = 1'b0;
    send(1'b1, 32'h10, 32'h0050_0093); step();
    send(1'b1, 32'h14, 32'h0050_0093); step();
    check("fl_pre_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    send(1'b1, 32'h18, 32'h0050_0093);
    step();
    flush = 1'b0;
    send(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready), 64'd1);
    check("fl_pc", 64'(out_pc), 64'd0);
    check("fl_instr", 64'(out_instr), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_no_ghost", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset while in SKID
    out_ready = 1'b0;
    send(1'b1, 32'h30, 32'h0050_0093); step();
    send(1'b1, 32'h34, 32'h0050_0093); step();
    send(1'b0, 32'h0, 32'h0);
    check("ar_pre_ready", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_ready", 64'(in_ready), 64'd1);
    check("ar_pc", 64'(out_pc), 64'd0);
    check("ar_imm", 64'(out_imm), 64'd0);
    check("ar_we", 64'(out_rd_we), 64'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    check("ar_post_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID→EX pipeline register for the pipelined RV32 core. It replaces the bare address latch with the following:
- a valid/ready handshake with a one-entry skid buffer;
- synchronous flush (bubble insertion);
- stall absorption without combinational ready paths.

It captures the decoded register addresses, operand data, PC, instruction, sign-extended immediate and an rd write-enable for the forwarding and hazard logic.

Parameters:
XLEN, 32, data/PC width (32 or 64)
RA_W, 5, register address width (4 for RV32E, 5 otherwise)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  ID presents a valid instruction
in_ready  out  1  block can accept (registered)
in_instr  in  32  instruction from IF/ID
in_pc  in  XLEN  PC of in_instr
in_rs1data  in  XLEN  register file read port 1
in_rs2data  in  XLEN  register file read port 2
flush  in  1  kill all held and incoming entries (branch/jump redirect)
out_valid  out  1  EX-side entry valid
out_ready  in  1  EX accepts the entry this cycle
out_instr  out  32  held instruction
out_pc  out  XLEN  held PC
out_rs1addr  out  RA_W  instr[15+:RA_W]
out_rs2addr  out  RA_W  instr[20+:RA_W]
out_rdaddr  out  RA_W  instr[7+:RA_W]
out_rs1data  out  XLEN  held rs1 data
out_rs2data  out  XLEN  held rs2 data
out_imm  out  XLEN  sign-extended immediate
out_rd_we  out  1  entry writes rd

Behaviour:
- Reset (async, rst=1): every output and all internal storage = 0, except in_ready = 1. Deassertion takes effect on the next clk edge.
- Storage: main entry M (drives out_*) and skid entry S. Each has a payload and a valid bit. All outputs come directly from M registers; there is no combinational input-to-output path.
- Accept condition: in_valid & in_ready. Transfer condition: out_valid & out_ready.
- in_ready = ~S.valid, registered.
- States, encoded by (M.valid, S.valid):
  - EMPTY (0,0)
  - FULL (1,0)
  - SKID (1,1)
  - (0,1) is illegal and unreachable.
- Transitions:
  - EMPTY: accept → FULL, M ← input.
  - FULL:
    - accept & transfer → FULL, M ← input.
    - accept & ~transfer → SKID, S ← input.
    - ~accept & transfer → EMPTY.
  - SKID: in_ready = 0, no accept. On transfer → FULL, M ← S, S.valid ← 0.
- Latency: 1 cycle from accept to out_valid when EMPTY, or when FULL with a transfer in the same cycle.
- Ordering: strict FIFO, maximum 2 entries. No entry is dropped or duplicated.
- flush has priority over everything in the same cycle:
  - M.valid, S.valid ← 0; all payload registers ← 0 (NOP-equivalent);
  - an input presented in that cycle is discarded;
  - state → EMPTY;
  - in_ready = 1 on the next cycle.
- Payload is held stable while out_valid & ~out_ready.
- Immediate, computed from in_instr before capture and sign-extended to XLEN:
  - I-type: opcodes 0000011, 0010011, 1100111.
  - S-type: 0100011.
  - B-type: 1100011, bit0 = 0.
  - U-type: 0110111, 0010111, low 12 = 0.
  - J-type: 1101111, bit0 = 0.
  - Any other opcode → 0.
- out_rd_we = 1 unless opcode ∈ {0100011, 1100011} or rdaddr == 0.
- When the entry is invalid, the payload value is don't-care for EX but must equal the last loaded value or 0 after reset/flush.

Decomposition:
- Shared package rv_pkg:
  - opcode localparams: OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC;
  - a packed payload struct type parametrised by XLEN/RA_W, or a width function for it.
- One combinational sub-module, id_imm_gen (instr → imm, rd_we), instantiated once on the input side.

Test Plan:
- Reset mid-stream: rst=1 asynchronously while in SKID → all out_* = 0 and in_ready = 1 immediately, before any clk edge.
- Streaming: out_ready=1; 4 back-to-back accepts, PCs 0x0/0x4/0x8/0xC → out_valid one cycle after each, PCs in order, in_ready stays 1.
- Stall/skid: out_ready=0 after the first accept; send PC 0x10 then 0x14 → SKID, in_ready=0. Raise out_ready → outputs 0x10 then 0x14 with no loss.
- Flush in SKID with in_valid=1 (PC 0x18) → next cycle out_valid=0, in_ready=1, out_pc=0. 0x18 never appears on the outputs.
- Decode, instr 0xFE112E23 (sw x1,-4(x2)) → rs1addr=2, rs2addr=1, imm=0xFFFFFFFC, rd_we=0.
- Decode, instr 0x00500093 (addi x1,x0,5) → rdaddr=1, imm=5, rd_we=1.
- Decode, instr 0x00000013 (nop) → rd_we=0.
